// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave front-panel blocks.
//   key_state_e  : keypad entry FSM states
//   BCD_W        : width of one BCD digit
//   BCD_MAX      : largest legal BCD key code
//   SEC_TENS_MAX : largest legal value in the seconds-tens position
package microwave_pkg;

    localparam int unsigned BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    localparam bcd_t BCD_MAX      = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStable = 2'd1,
        StHeld   = 2'd2
    } key_state_e;

endpackage

// File: rtl/keypad_entry_loader_if.sv
// Keypad entry bus.
//   digit/validn : BCD key code and active-low strobe from the priority encoder
//   run          : magnetron on, freezes entry
//   flush        : synchronous clear of the entry buffer
//   sec_ones/sec_tens/mins : registered BCD entry buffer
//   load_pulse   : one-cycle strobe when a new buffer value appears
//   entry_count  : digits entered since reset/flush, saturating at 3
//   rejected     : one-cycle strobe for a debounced key that was discarded
// master drives keys and controls; slave (the loader) drives the buffer side.
interface keypad_entry_loader_if;

    logic [microwave_pkg::BCD_W-1:0] digit;
    logic                            validn;
    logic                            run;
    logic                            flush;
    logic [microwave_pkg::BCD_W-1:0] sec_ones;
    logic [microwave_pkg::BCD_W-1:0] sec_tens;
    logic [microwave_pkg::BCD_W-1:0] mins;
    logic                            load_pulse;
    logic [1:0]                      entry_count;
    logic                            rejected;

    modport master (
        output digit, validn, run, flush,
        input  sec_ones, sec_tens, mins, load_pulse, entry_count, rejected
    );

    modport slave (
        input  digit, validn, run, flush,
        output sec_ones, sec_tens, mins, load_pulse, entry_count, rejected
    );

endinterface

// File: rtl/key_debounce.sv
// Stable-count tracker for the keypad loader.
//   clock   : system clock
//   clearn  : asynchronous active-low reset
//   restart : this edge starts a new count at 1
//   enable  : this edge extends the current count by 1
//   done    : this edge brings the count to DEBOUNCE_CYCLES
// The count returns to 0 on any edge where neither restart nor enable is set.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic clearn,
    input  logic restart,
    input  logic enable,
    output logic done
);

    localparam logic [3:0] Target = 4'(DEBOUNCE_CYCLES);

    logic [3:0] count_q, count_d;

    always_comb begin
        count_d = 4'd0;
        if (restart) begin
            count_d = 4'd1;
        end else if (enable) begin
            count_d = (count_q == 4'hf) ? 4'hf : count_q + 4'd1;
        end
    end

    // Done is combinational so the accept lands on the completing edge itself.
    assign done = (restart || enable) && (count_d == Target);

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/keypad_entry_loader.sv
// Keypad entry loader: debounces keypad digits and shifts accepted ones into a
// three-digit BCD buffer (mins : sec_tens : sec_ones) for the cook timer.
//   clock  : system clock
//   clearn : asynchronous active-low reset
//   kp     : keypad_entry_loader_if.slave (key input, control, buffer outputs)
// Optional build macro SEC_TENS_CLAMP_EN: refuse any accept that would move a
// value above 5 into sec_tens; the key is consumed and rejected pulses instead.
module keypad_entry_loader
    import microwave_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  clearn,
    keypad_entry_loader_if.slave  kp
);

    key_state_e state_q, state_d;
    bcd_t       latched_q, latched_d;
    bcd_t       ones_q, ones_d;
    bcd_t       tens_q, tens_d;
    bcd_t       mins_q, mins_d;
    logic [1:0] count_q, count_d;
    logic       load_q, load_d;
    logic       rej_q, rej_d;

    logic live;
    logic restart;
    logic enable;
    logic done;
    logic clamp_hit;

    // Debounce only runs when neither flush nor run overrides the FSM.
    assign live    = !kp.flush && !kp.run && !kp.validn;
    assign restart = live && ((state_q == StIdle) ||
                              ((state_q == StStable) && (kp.digit != latched_q)));
    assign enable  = live && (state_q == StStable) && (kp.digit == latched_q);

`ifdef SEC_TENS_CLAMP_EN
    assign clamp_hit = (ones_q > SEC_TENS_MAX);
`else
    assign clamp_hit = 1'b0;
`endif

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock   (clock),
        .clearn  (clearn),
        .restart (restart),
        .enable  (enable),
        .done    (done)
    );

    always_comb begin
        state_d   = state_q;
        latched_d = latched_q;
        ones_d    = ones_q;
        tens_d    = tens_q;
        mins_d    = mins_q;
        count_d   = count_q;
        load_d    = 1'b0;
        rej_d     = 1'b0;

        if (kp.flush) begin
            state_d = StIdle;
            ones_d  = '0;
            tens_d  = '0;
            mins_d  = '0;
            count_d = 2'd0;
        end else if (kp.run) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!kp.validn) begin
                        state_d = StStable;
                    end
                end
                StStable: begin
                    if (kp.validn) begin
                        state_d = StIdle;
                    end
                end
                StHeld: begin
                    if (kp.validn) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (restart) begin
                latched_d = kp.digit;
            end

            // Every debounced key is consumed (HELD) whether it loads or not.
            if (done) begin
                state_d = StHeld;
                if (kp.digit > BCD_MAX || clamp_hit) begin
                    rej_d = 1'b1;
                end else begin
                    mins_d  = tens_q;
                    tens_d  = ones_q;
                    ones_d  = kp.digit;
                    load_d  = 1'b1;
                    count_d = (count_q == 2'd3) ? 2'd3 : count_q + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            state_q   <= StIdle;
            latched_q <= '0;
            ones_q    <= '0;
            tens_q    <= '0;
            mins_q    <= '0;
            count_q   <= 2'd0;
            load_q    <= 1'b0;
            rej_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            latched_q <= latched_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            mins_q    <= mins_d;
            count_q   <= count_d;
            load_q    <= load_d;
            rej_q     <= rej_d;
        end
    end

    assign kp.sec_ones    = ones_q;
    assign kp.sec_tens    = tens_q;
    assign kp.mins        = mins_q;
    assign kp.entry_count = count_q;
    assign kp.load_pulse  = load_q;
    assign kp.rejected    = rej_q;

endmodule
